commit_ctrl: RTL and testbench

ROB-head commit controller of the out-of-order core. Each cycle it inspects the reorder-buffer head entry and decides whether to retire it. Retirement can write the architectural register file through the commit port, hand a store to the load/store buffer, or redirect the front end on a branch mispredict. It is the only writer of the register file's commit port and the only source of pipeline flush.

---
 rtl/commit_ctrl.sv | 67 ++++++
 tb/tb_commit_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// commit_ctrl: ROB-head retirement controller driving the commit port, store release and flush
module commit_ctrl #(
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               head_valid,
  input  logic               head_ready,
  input  logic [ROB_LOG-1:0] head_tag,
  input  logic [1:0]         head_type,
  input  logic [4:0]         head_dest,
  input  logic [31:0]        head_value,
  input  logic               head_mispredict,
  input  logic [31:0]        head_target,
  output logic               head_pop,
  output logic               commit_valid,
  output logic [4:0]         commit_dest,
  output logic [31:0]        commit_value,
  output logic [ROB_LOG-1:0] commit_reorder,
  output logic               store_req,
  output logic [ROB_LOG-1:0] store_tag,
  input  logic               store_done,
  output logic               flush,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        retired_cnt
);
  localparam logic [1:0] COMMIT = 2'd0, STORE_WAIT = 2'd1, FLUSH = 2'd2;
  logic [1:0] state;
  logic accept, store_pop, do_commit, do_flush, do_store;
  always_comb begin
    accept = state == COMMIT && rdy && head_valid && head_ready && head_tag != '0;
    store_pop = state == STORE_WAIT && rdy && store_done;
    do_store = accept && head_type == 2'b01;
    do_commit = accept && !head_type[0] && head_dest != 5'd0;
    do_flush = accept && head_type == 2'b10 && head_mispredict;
    head_pop = !rst && ((accept && !do_store) || store_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COMMIT;
      commit_valid <= 1'b0;
      commit_dest <= '0;
      commit_value <= '0;
      commit_reorder <= '0;
      store_req <= 1'b0;
      store_tag <= '0;
      flush <= 1'b0;
      redirect_pc <= '0;
      retired_cnt <= '0;
    end else begin
      commit_valid <= do_commit;
      flush <= do_flush;
      retired_cnt <= retired_cnt + 32'(head_pop);
      if (do_commit) begin
        commit_dest <= head_dest;
        commit_value <= head_value;
        commit_reorder <= head_tag;
      end
      if (do_flush) redirect_pc <= head_target;
      if (do_store) store_tag <= head_tag;
      store_req <= do_store ? 1'b1 : store_pop ? 1'b0 : store_req;
      state <= do_store ? STORE_WAIT : do_flush ? FLUSH :
               store_pop ? COMMIT : (state == FLUSH && rdy) ? COMMIT : state;
    end
  end
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed scenario tests for the ROB-head commit controller
module tb_commit_ctrl;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic head_valid = 1'b0, head_ready = 1'b0, head_mispredict = 1'b0, store_done = 1'b0;
  logic [3:0] head_tag = '0;
  logic [1:0] head_type = '0;
  logic [4:0] head_dest = '0;
  logic [31:0] head_value = '0, head_target = '0;
  logic head_pop, commit_valid, store_req, flush;
  logic [4:0] commit_dest;
  logic [31:0] commit_value, redirect_pc, retired_cnt;
  logic [3:0] commit_reorder, store_tag;
  int errors = 0, checks = 0;

  commit_ctrl #(.ROB_LOG(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .head_valid(head_valid), .head_ready(head_ready),
    .head_tag(head_tag), .head_type(head_type), .head_dest(head_dest), .head_value(head_value),
    .head_mispredict(head_mispredict), .head_target(head_target), .head_pop(head_pop),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
    .commit_reorder(commit_reorder), .store_req(store_req), .store_tag(store_tag),
    .store_done(store_done), .flush(flush), .redirect_pc(redirect_pc), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic [3:0] t, input logic [1:0] ty, input logic [4:0] d,
                          input logic [31:0] v, input logic mp, input logic [31:0] tgt);
    head_valid = 1'b1; head_ready = 1'b1; head_tag = t; head_type = ty;
    head_dest = d; head_value = v; head_mispredict = mp; head_target = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_head(4'd1, 2'b00, 5'd5, 32'd10, 1'b0, 32'd0);
    tick();
    #1;
    checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", head_pop); end
    checks++;
    if ({commit_valid, commit_dest, commit_value, commit_reorder, store_req, store_tag, flush, redirect_pc, retired_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs: cv=%b cd=%0d cval=%0h cr=%0d sr=%b st=%0d fl=%b pc=%0h cnt=%0d want all 0",
        commit_valid, commit_dest, commit_value, commit_reorder, store_req, store_tag, flush, redirect_pc, retired_cnt);
    end
    head_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reg_write();
    logic [4:0] d [3] = '{5'd5, 5'd6, 5'd7};
    logic [31:0] v [3] = '{32'd10, 32'd20, 32'd30};
    for (int i = 0; i < 3; i++) begin
      set_head(4'(i + 1), 2'b00, d[i], v[i], 1'b0, 32'd0);
      #1;
      checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL rw_pop%0d: got %b want 1", i, head_pop); end
      tick();
      checks++;
      if (commit_valid !== 1'b1 || commit_dest !== d[i] || commit_value !== v[i] || commit_reorder !== 4'(i + 1)) begin
        errors++; $display("FAIL rw_commit%0d: got v=%b x%0d=%0d tag=%0d want v=1 x%0d=%0d tag=%0d",
          i, commit_valid, commit_dest, commit_value, commit_reorder, d[i], v[i], i + 1);
      end
    end
    head_valid = 1'b0;
    checks++; if (retired_cnt !== 32'd3) begin errors++; $display("FAIL rw_cnt: got %0d want 3", retired_cnt); end
    tick();
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rw_idle: commit_valid got %b want 0", commit_valid); end
  endtask

  task automatic test_x0();
    set_head(4'd4, 2'b00, 5'd0, 32'd99, 1'b0, 32'd0);
    #1;
    checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL x0_pop: got %b want 1", head_pop); end
    tick();
    head_valid = 1'b0;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL x0_commit: got %b want 0", commit_valid); end
    checks++; if (retired_cnt !== 32'd4) begin errors++; $display("FAIL x0_cnt: got %0d want 4", retired_cnt); end
  endtask

  task automatic test_store();
    set_head(4'd5, 2'b01, 5'd3, 32'd55, 1'b0, 32'd0);
    #1;
    checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL st_accept_pop: got %b want 0", head_pop); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (store_req !== 1'b1 || store_tag !== 4'd5 || head_pop !== 1'b0 || commit_valid !== 1'b0) begin
        errors++; $display("FAIL st_wait%0d: req=%b tag=%0d pop=%b cv=%b want req=1 tag=5 pop=0 cv=0",
          i, store_req, store_tag, head_pop, commit_valid);
      end
      tick();
    end
    store_done = 1'b1;
    #1;
    checks++; if (head_pop !== 1'b1 || store_req !== 1'b1) begin errors++; $display("FAIL st_pop: pop=%b req=%b want 1 1", head_pop, store_req); end
    tick();
    head_valid = 1'b0;
    checks++;
    if (store_req !== 1'b0 || commit_valid !== 1'b0 || retired_cnt !== 32'd5) begin
      errors++; $display("FAIL st_done: req=%b cv=%b cnt=%0d want 0 0 5", store_req, commit_valid, retired_cnt);
    end
    store_done = 1'b0;
  endtask

  task automatic test_branch();
    set_head(4'd6, 2'b10, 5'd1, 32'h104, 1'b1, 32'h200);
    #1;
    checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL br_pop: got %b want 1", head_pop); end
    tick();
    set_head(4'd7, 2'b00, 5'd8, 32'd70, 1'b0, 32'd0);
    checks++;
    if (commit_valid !== 1'b1 || commit_dest !== 5'd1 || commit_value !== 32'h104 || commit_reorder !== 4'd6) begin
      errors++; $display("FAIL br_commit: v=%b x%0d=%0h tag=%0d want v=1 x1=104 tag=6", commit_valid, commit_dest, commit_value, commit_reorder);
    end
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL br_flush: flush=%b pc=%0h want 1 200", flush, redirect_pc); end
    #1;
    checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL br_flush_pop: got %b want 0", head_pop); end
    tick();
    checks++; if (flush !== 1'b0 || commit_valid !== 1'b0) begin errors++; $display("FAIL br_after: flush=%b cv=%b want 0 0", flush, commit_valid); end
    #1;
    checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL br_resume_pop: got %b want 1", head_pop); end
    tick();
    head_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || commit_dest !== 5'd8 || commit_value !== 32'd70 || retired_cnt !== 32'd7) begin
      errors++; $display("FAIL br_resume: v=%b x%0d=%0d cnt=%0d want v=1 x8=70 cnt=7", commit_valid, commit_dest, commit_value, retired_cnt);
    end
  endtask

  task automatic test_rdy_stall();
    set_head(4'd8, 2'b00, 5'd9, 32'd90, 1'b0, 32'd0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (head_pop !== 1'b0) begin errors++; $display("FAIL stall_pop%0d: got %b want 0", i, head_pop); end
      tick();
      checks++;
      if (commit_valid !== 1'b0 || flush !== 1'b0 || retired_cnt !== 32'd7) begin
        errors++; $display("FAIL stall%0d: cv=%b flush=%b cnt=%0d want 0 0 7", i, commit_valid, flush, retired_cnt);
      end
    end
    rdy = 1'b1;
    #1;
    checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL stall_resume_pop: got %b want 1", head_pop); end
    tick();
    head_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || commit_dest !== 5'd9 || commit_value !== 32'd90 || retired_cnt !== 32'd8) begin
      errors++; $display("FAIL stall_resume: v=%b x%0d=%0d cnt=%0d want v=1 x9=90 cnt=8", commit_valid, commit_dest, commit_value, retired_cnt);
    end
  endtask

  task automatic test_reset_store();
    set_head(4'd9, 2'b01, 5'd0, 32'd0, 1'b0, 32'd0);
    tick();
    checks++; if (store_req !== 1'b1 || store_tag !== 4'd9) begin errors++; $display("FAIL rs_req: req=%b tag=%0d want 1 9", store_req, store_tag); end
    rst = 1'b1;
    tick();
    checks++;
    if ({commit_valid, commit_dest, commit_value, commit_reorder, store_req, store_tag, flush, redirect_pc, retired_cnt} !== '0) begin
      errors++; $display("FAIL rs_outputs: cv=%b sr=%b st=%0d fl=%b pc=%0h cnt=%0d want all 0",
        commit_valid, store_req, store_tag, flush, redirect_pc, retired_cnt);
    end
    rst = 1'b0;
    set_head(4'd10, 2'b00, 5'd2, 32'd123, 1'b0, 32'd0);
    #1;
    checks++; if (head_pop !== 1'b1) begin errors++; $display("FAIL rs_commit_state_pop: got %b want 1", head_pop); end
    tick();
    head_valid = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || commit_value !== 32'd123 || retired_cnt !== 32'd1) begin
      errors++; $display("FAIL rs_resume: v=%b val=%0d cnt=%0d want 1 123 1", commit_valid, commit_value, retired_cnt);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_reg_write();
    test_x0();
    test_store();
    test_branch();
    test_rdy_stall();
    test_reset_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
